dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEMORY stage load/store requests: the target end of the core's data-memory interface.
- Accepts one request at a time over a valid/ready handshake, inserts a configurable number of wait states, then returns a response over a second valid/ready handshake.
- Supports RV32 byte/half/word accesses, little-endian, with load sign/zero extension.
- Owns a byte-addressed RAM of 2^ADDRESS_WIDTH bytes; `busy` feeds the hazard/stall logic.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and access-legality helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_H, SZ_HU: mis = addr_lo[0];
      SZ_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_legal_size(input logic [2:0] size);
    logic legal;
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and byte/half extraction with extension for loads,
// relative to the naturally aligned 32-bit word containing the access.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;

  // Lane enables, store shift and load extension
  always_comb begin
    byte_en   = 4'b0000;
    wlane     = wdata << {addr_lo, 3'b000};
    shifted_s = rword >> {addr_lo, 3'b000};
    rdata     = 32'h0000_0000;
    case (size)
      SZ_B: begin
        byte_en = 4'b0001 << addr_lo;
        rdata   = {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      SZ_BU: begin
        byte_en = 4'b0001 << addr_lo;
        rdata   = {24'h00_0000, shifted_s[7:0]};
      end
      SZ_H: begin
        byte_en = 4'b0011 << addr_lo;
        rdata   = {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      SZ_HU: begin
        byte_en = 4'b0011 << addr_lo;
        rdata   = {16'h0000, shifted_s[15:0]};
      end
      SZ_W: begin
        byte_en = 4'b1111;
        rdata   = shifted_s;
      end
      default: begin
        byte_en = 4'b0000;
        rdata   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's data-memory interface: one request at a time,
// LATENCY wait states, byte-addressed RAM, response held until accepted.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_size,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t              state_r;
  logic [3:0]               cnt_r;
  logic                     write_r;
  logic [2:0]               size_r;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic                     rsp_valid_r;
  logic [DATA_WIDTH-1:0]    rdata_r;
  logic                     err_r;
  logic [7:0]               mem_r [2**ADDRESS_WIDTH];

  logic                     acc_write_s;
  logic [2:0]               acc_size_s;
  logic [ADDRESS_WIDTH-1:0] acc_addr_s;
  logic [DATA_WIDTH-1:0]    acc_wdata_s;
  logic                     access_s;
  logic                     acc_err_s;
  logic                     do_write_s;
  logic [ADDRESS_WIDTH-3:0] word_s;
  logic [3:0]               byte_en_s;
  logic [31:0]              wlane_s;
  logic [31:0]              rword_s;
  logic [31:0]              load_s;
  logic [DATA_WIDTH-1:0]    rsp_data_s;

  assign req_ready = rst && (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

  // Zero-latency builds access on the accept edge straight from the request bus
  always_comb begin
    if (ZERO_LAT) begin
      acc_write_s = req_write;
      acc_size_s  = req_size;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
      access_s    = req_valid && req_ready;
    end else begin
      acc_write_s = write_r;
      acc_size_s  = size_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      access_s    = (state_r == WAIT) && (cnt_r == 4'd0);
    end
  end

  assign acc_err_s  = !is_legal_size(acc_size_s) || is_misaligned(acc_size_s, acc_addr_s[1:0]);
  assign do_write_s = access_s && acc_write_s && !acc_err_s;
  assign word_s     = acc_addr_s[ADDRESS_WIDTH-1:2];
  assign rword_s    = {mem_r[{word_s, 2'd3}], mem_r[{word_s, 2'd2}],
                       mem_r[{word_s, 2'd1}], mem_r[{word_s, 2'd0}]};
  assign rsp_data_s = (acc_err_s || acc_write_s) ? '0 : load_s;

  dmem_lane_align u_align (
    .size    (acc_size_s),
    .addr_lo (acc_addr_s[1:0]),
    .wdata   (acc_wdata_s),
    .rword   (rword_s),
    .byte_en (byte_en_s),
    .wlane   (wlane_s),
    .rdata   (load_s)
  );

  // RAM byte-lane writes; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (do_write_s && byte_en_s[0]) mem_r[{word_s, 2'd0}] <= wlane_s[7:0];
    if (do_write_s && byte_en_s[1]) mem_r[{word_s, 2'd1}] <= wlane_s[15:8];
    if (do_write_s && byte_en_s[2]) mem_r[{word_s, 2'd2}] <= wlane_s[23:16];
    if (do_write_s && byte_en_s[3]) mem_r[{word_s, 2'd3}] <= wlane_s[31:24];
  end

  // Request/response sequencing; the response is captured on the access edge
  // and presented one registered cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      write_r     <= 1'b0;
      size_r      <= 3'b000;
      addr_r      <= '0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r <= req_write;
            size_r  <= req_size;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            if (ZERO_LAT) begin
              state_r <= RESP;
              rdata_r <= rsp_data_s;
              err_r   <= acc_err_s;
            end else begin
              cnt_r   <= CNT_INIT;
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
            rdata_r <= rsp_data_s;
            err_r   <= acc_err_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2, 0, 3) driven independently.
module tb_dmem_responder;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic        clk = 1'b0;
  logic [2:0]  rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0]  req_size  [3];
  logic [7:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [31:0] rsp_rdata [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .ADDRESS_WIDTH (8),
      .DATA_WIDTH    (32),
      .LATENCY       (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic txn(input int d, input logic wr, input logic [2:0] sz, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input int hold, input string tag);
    int n;
    check({tag, " req_ready"}, {31'd0, req_ready[d]}, 32'd1);
    req_write[d] = wr;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = ~wr;
    req_addr[d]  = ~a;
    req_wdata[d] = ~wd;
    n = 0;
    while (!rsp_valid[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, lat_of(d) + 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, rsp_valid[d]}, 32'd1);
      check({tag, " hold rdata"}, rsp_rdata[d], exp_rd);
      check({tag, " hold busy"}, {31'd0, busy[d]}, 32'd1);
      check({tag, " hold ready"}, {31'd0, req_ready[d]}, 32'd0);
    end
    check({tag, " rdata"}, rsp_rdata[d], exp_rd);
    check({tag, " err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({tag, " done valid"}, {31'd0, rsp_valid[d]}, 32'd0);
    check({tag, " done busy"}, {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    rst       = 3'b000;
    req_valid = 3'b000;
    req_write = 3'b000;
    rsp_ready = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_size[i]  = 3'b000;
      req_addr[i]  = 8'h00;
      req_wdata[i] = 32'h0000_0000;
    end
    repeat (3) @(negedge clk);
    check("rst req_ready", {31'd0, req_ready[0]}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst busy", {31'd0, busy[0]}, 32'd0);
    check("rst rdata", rsp_rdata[0], 32'h0000_0000);
    check("rst err", {31'd0, rsp_err[0]}, 32'd0);
    rst = 3'b111;
    @(negedge clk);

    // LATENCY = 2
    txn(0, 1'b1, W,  8'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, "sw10");
    txn(0, 1'b0, W,  8'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, "lw10");
    txn(0, 1'b0, B,  8'h13, 32'h0,         32'hFFFF_FFDE, 1'b0, 0, "lb13");
    txn(0, 1'b0, BU, 8'h13, 32'h0,         32'h0000_00DE, 1'b0, 0, "lbu13");
    txn(0, 1'b0, H,  8'h10, 32'h0,         32'hFFFF_BEEF, 1'b0, 0, "lh10");
    txn(0, 1'b0, HU, 8'h12, 32'h0,         32'h0000_DEAD, 1'b0, 0, "lhu12");
    txn(0, 1'b1, B,  8'h11, 32'h0000_0055, 32'h0000_0000, 1'b0, 0, "sb11");
    txn(0, 1'b0, W,  8'h10, 32'h0,         32'hDEAD_55EF, 1'b0, 0, "lw10 after sb");
    txn(0, 1'b0, W,  8'h12, 32'h0,         32'h0000_0000, 1'b1, 0, "lw12 misaligned");
    txn(0, 1'b1, H,  8'h11, 32'h0000_AAAA, 32'h0000_0000, 1'b1, 0, "sh11 misaligned");
    txn(0, 1'b0, W,  8'h10, 32'h0,         32'hDEAD_55EF, 1'b0, 0, "lw10 unchanged");
    txn(0, 1'b0, B,  8'h11, 32'h0,         32'h0000_0055, 1'b0, 0, "lb11 positive");
    txn(0, 1'b1, H,  8'h12, 32'h0000_8001, 32'h0000_0000, 1'b0, 0, "sh12");
    txn(0, 1'b0, W,  8'h10, 32'h0,         32'h8001_55EF, 1'b0, 0, "lw10 after sh");
    txn(0, 1'b0, H,  8'h12, 32'h0,         32'hFFFF_8001, 1'b0, 0, "lh12");
    txn(0, 1'b0, 3'b011, 8'h10, 32'h0,     32'h0000_0000, 1'b1, 0, "illegal size load");
    txn(0, 1'b1, 3'b111, 8'h10, 32'h0,     32'h0000_0000, 1'b1, 0, "illegal size store");
    txn(0, 1'b0, W,  8'h10, 32'h0,         32'h8001_55EF, 1'b0, 5, "lw10 backpressure");

    // LATENCY = 0
    txn(1, 1'b1, W,  8'h40, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0, "l0 sw40");
    txn(1, 1'b0, W,  8'h40, 32'h0,         32'hCAFE_F00D, 1'b0, 0, "l0 lw40");
    txn(1, 1'b0, HU, 8'h42, 32'h0,         32'h0000_CAFE, 1'b0, 0, "l0 lhu42");
    txn(1, 1'b0, B,  8'h40, 32'h0,         32'h0000_000D, 1'b0, 0, "l0 lb40");

    // LATENCY = 3 with reset during a store's wait states
    txn(2, 1'b1, W,  8'h20, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, "l3 sw20 clear");
    req_write[2] = 1'b1;
    req_size[2]  = W;
    req_addr[2]  = 8'h20;
    req_wdata[2] = 32'h1234_5678;
    req_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    #1 rst[2] = 1'b0;
    #1;
    check("midrst req_ready", {31'd0, req_ready[2]}, 32'd0);
    check("midrst rsp_valid", {31'd0, rsp_valid[2]}, 32'd0);
    check("midrst busy", {31'd0, busy[2]}, 32'd0);
    check("midrst rdata", rsp_rdata[2], 32'h0000_0000);
    check("midrst err", {31'd0, rsp_err[2]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    txn(2, 1'b0, W,  8'h20, 32'h0,         32'h0000_0000, 1'b0, 0, "l3 lw20 discarded");
    txn(2, 1'b1, W,  8'h24, 32'hA5A5_0F0F, 32'h0000_0000, 1'b0, 0, "l3 sw24");
    txn(2, 1'b0, W,  8'h24, 32'h0,         32'hA5A5_0F0F, 1'b0, 0, "l3 lw24");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
